// File: rtl/y86_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port between the core (m0) and a DMA/debug loader (m1).
// Optional m0 lock for atomic fetch plus load/store: define Y86_ARB_LOCK_EN.
module y86_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
`ifdef Y86_ARB_LOCK_EN
    input  logic          m0_lock,
`endif
    output logic          m0_gnt,
    output logic          m0_done,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          timeout_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          lastGrant_q, lastGrant_d;
    logic [7:0]    waitCnt_q, waitCnt_d;
    logic          abort_q, abort_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          tErr_q, tErr_d;
    logic          grantValid, grantSel;

`ifdef Y86_ARB_LOCK_EN
    logic          lockPend_q, lockPend_d;
    logic [1:0]    m0Streak_q, m0Streak_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lastGrant_q <= 1'b1;
            waitCnt_q   <= '0;
            abort_q     <= 1'b0;
            rdata_q     <= '0;
            tErr_q      <= 1'b0;
`ifdef Y86_ARB_LOCK_EN
            lockPend_q  <= 1'b0;
            m0Streak_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lastGrant_q <= lastGrant_d;
            waitCnt_q   <= waitCnt_d;
            abort_q     <= abort_d;
            rdata_q     <= rdata_d;
            tErr_q      <= tErr_d;
`ifdef Y86_ARB_LOCK_EN
            lockPend_q  <= lockPend_d;
            m0Streak_q  <= m0Streak_d;
`endif
        end
    end

    // Under contention the master that did not win last time is chosen.
    always_comb begin
        grantValid = m0_req | m1_req;
        grantSel   = (m0_req & m1_req) ? ~lastGrant_q : m1_req;
`ifdef Y86_ARB_LOCK_EN
        if (lockPend_q) begin
            grantValid = 1'b1;
            grantSel   = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lastGrant_d = lastGrant_q;
        waitCnt_d   = waitCnt_q;
        abort_d     = abort_q;
        rdata_d     = rdata_q;
        tErr_d      = tErr_q;
`ifdef Y86_ARB_LOCK_EN
        lockPend_d  = lockPend_q;
        m0Streak_d  = m0Streak_q;
`endif
        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    state_d     = ACCESS;
                    owner_d     = grantSel;
                    we_d        = grantSel ? m1_we : m0_we;
                    addr_d      = grantSel ? m1_addr : m0_addr;
                    wdata_d     = grantSel ? m1_wdata : m0_wdata;
                    lastGrant_d = grantSel;
                    waitCnt_d   = '0;
                    abort_d     = 1'b0;
`ifdef Y86_ARB_LOCK_EN
                    lockPend_d  = 1'b0;
                    m0Streak_d  = grantSel ? 2'd0 : ((m0Streak_q == 2'd2) ? 2'd2 : m0Streak_q + 2'd1);
`endif
                end
            end
            ACCESS: begin
                // A ready on the final allowed cycle still completes normally.
                if (mem_ready) begin
                    if (!we_q) rdata_d = mem_rdata;
                    abort_d = 1'b0;
                    state_d = DONE;
                end else if (waitCnt_q == LastWait) begin
                    abort_d = 1'b1;
                    tErr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                waitCnt_d = '0;
`ifdef Y86_ARB_LOCK_EN
                lockPend_d = (owner_q == 1'b0) && m0_lock && m0_req && (m0Streak_q < 2'd2);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_done   = 1'b0;
        m1_done   = 1'b0;
        err       = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ACCESS: begin
                m0_gnt    = ~owner_q;
                m1_gnt    = owner_q;
                mem_re    = ~we_q;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            DONE: begin
                m0_gnt  = ~owner_q;
                m1_gnt  = owner_q;
                m0_done = ~owner_q;
                m1_done = owner_q;
                err     = abort_q;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign rdata       = rdata_q;
    assign timeout_err = tErr_q;

endmodule
